// File: rtl/dev_fsm_pkg.sv
// Command-bit positions and FSM state encoding shared by dev_fsm and its users.
// Bits above b_tx are reserved and ignored by the decoder.
// Pure declarations, no logic.
package cmd_bits;

  localparam int b_addop  = 0;
  localparam int b_subop  = 1;
  localparam int b_addres = 2;
  localparam int b_subres = 3;
  localparam int b_op_2   = 4;
  localparam int b_tx     = 5;

  // Number of command bits that carry meaning.
  localparam int CMD_W = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP1 = 3'd1,
    GET_OP2 = 3'd2,
    EXEC    = 3'd3,
    TX      = 3'd4
  } state_t;

endpackage

// File: rtl/dev_fsm.sv
// Command-driven accumulator: command byte, optional operand bytes, one EXEC, optional TX.
// Latency: cmd edge + one edge per operand + EXEC edge; drdy in the cycle after EXEC.
// cs is only sampled in IDLE; busy covers the whole transaction.
module dev_fsm
  import cmd_bits::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          drdy
);

  state_t             state, state_n;
  logic [CMD_W-1:0]   cmd, cmd_n;
  logic [DW-1:0]      op1, op1_n;
  logic [DW-1:0]      op2, op2_n;
  logic [DW-1:0]      res, res_n;

  // Any arithmetic bit means the command needs an op1 byte.
  function automatic logic has_arith(input logic [CMD_W-1:0] c);
    return c[b_addop] | c[b_subop] | c[b_addres] | c[b_subres];
  endfunction

  // Single arithmetic op, fixed priority, unsigned wrap-around.
  function automatic logic [DW-1:0] alu(input logic [CMD_W-1:0] c,
                                        input logic [DW-1:0]    a,
                                        input logic [DW-1:0]    b,
                                        input logic [DW-1:0]    r);
    if (c[b_addop])       return a + b;
    else if (c[b_subop])  return a - b;
    else if (c[b_addres]) return r + a;
    else if (c[b_subres]) return r - a;
    else                  return r;
  endfunction

  // Next-state and next-register values; everything holds unless the state says otherwise.
  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    op1_n   = op1;
    op2_n   = op2;
    res_n   = res;
    unique case (state)
      IDLE: begin
        if (cs) begin
          cmd_n = din[CMD_W-1:0];
          if (has_arith(din[CMD_W-1:0])) state_n = GET_OP1;
          else if (din[b_op_2])          state_n = GET_OP2;
          else if (din[b_tx])            state_n = TX;
          else                           state_n = IDLE;
        end
      end
      GET_OP1: begin
        op1_n   = din;
        state_n = cmd[b_op_2] ? GET_OP2 : EXEC;
      end
      GET_OP2: begin
        // op2 is written here, so EXEC always sees the freshest value.
        op2_n   = din;
        state_n = EXEC;
      end
      EXEC: begin
        res_n   = alu(cmd, op1, op2, res);
        state_n = cmd[b_tx] ? TX : IDLE;
      end
      TX: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, data registers and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd   <= '0;
      op1   <= '0;
      op2   <= '0;
      res   <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      drdy  <= 1'b0;
    end else begin
      state <= state_n;
      cmd   <= cmd_n;
      op1   <= op1_n;
      op2   <= op2_n;
      res   <= res_n;
      busy  <= (state_n != IDLE);
      drdy  <= (state_n == TX);
      if (state_n == TX) dout <= res_n;
    end
  end

endmodule

// File: tb/tb_dev_fsm.sv
// Self-checking bench for dev_fsm: reference model pushes expected TX values, monitor pops on drdy.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Each scenario task performs its own inline checks.
module tb_dev_fsm;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs  = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          busy;
  logic          drdy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_res = '0;
  logic [DW-1:0] m_op1 = '0;
  logic [DW-1:0] m_op2 = '0;
  logic          prev_drdy = 1'b0;

  dev_fsm #(.DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .drdy (drdy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every drdy strobe must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && drdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL drdy_unexpected: got strobe with dout=%02h, required no strobe", dout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_err++;
          $display("FAIL tx_dout: got %02h, required %02h", dout, e);
        end
      end
      if (prev_drdy) begin
        n_cmp++;
        n_err++;
        $display("FAIL drdy_width: got 2+ cycles high, required 1");
      end
    end
    prev_drdy = drdy;
  end

  function automatic logic [DW-1:0] model_alu(input logic [7:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] r);
    if (c[0])      return a + b;
    else if (c[1]) return a - b;
    else if (c[2]) return r + a;
    else if (c[3]) return r - a;
    else           return r;
  endfunction

  function automatic void model_cmd(input logic [7:0] c, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    logic arith;
    arith = |c[3:0];
    if (arith) m_op1 = a;
    if (c[4])  m_op2 = b;
    if (arith || c[4]) m_res = model_alu(c, m_op1, m_op2, m_res);
    if (c[5])  exp_q.push_back(m_res);
  endfunction

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b after 20 cycles, required 0", name, busy);
    end
  endtask

  // Issues one full command with the operand bytes it needs.
  task automatic issue(input logic [7:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic exp_busy;
    exp_busy = |c[5:0];
    model_cmd(c, a, b);
    @(negedge clk);
    cs  = 1'b1;
    din = c;
    @(negedge clk);
    cs  = 1'b0;
    din = '0;
    n_cmp++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL busy_after_cmd(%02h): got %b, required %b", c, busy, exp_busy);
    end
    if (|c[3:0]) begin
      din = a;
      @(negedge clk);
    end
    if (c[4]) begin
      din = b;
      @(negedge clk);
    end
    din = '0;
    wait_idle("issue");
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || drdy !== 1'b0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b drdy=%b dout=%02h, required 0 0 00", busy, drdy, dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_op2_load();
    issue(8'h10, 8'h00, 8'h05);
    repeat (3) @(negedge clk);
    issue(8'h20, 8'h00, 8'h00);
  endtask

  task automatic test_add();
    issue(8'h11, 8'h03, 8'h05);
    issue(8'h20, 8'h00, 8'h00);
  endtask

  task automatic test_accumulate();
    issue(8'h04, 8'h0A, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h08, 8'h14, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
  endtask

  task automatic test_wrap();
    issue(8'h04, 8'h01, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h04, 8'h01, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h28, 8'h01, 8'h00);
    issue(8'hC0, 8'h00, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
  endtask

  task automatic test_subop_and_reserved();
    issue(8'hD2, 8'h02, 8'h05);
    issue(8'h22, 8'h10, 8'h00);
  endtask

  task automatic test_cs_ignored();
    model_cmd(8'h21, 8'h05, 8'h00);
    @(negedge clk);
    cs = 1'b1; din = 8'h21;
    @(negedge clk);
    din = 8'h05;
    @(negedge clk);
    din = 8'h20;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL cs_busy_tx: got busy=%b, required 1", busy);
    end
    @(negedge clk);
    cs = 1'b0; din = '0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL cs_ignored_idle: got busy=%b, required 0", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cs = 1'b1; din = 8'h01;
    @(negedge clk);
    cs = 1'b0; din = 8'h77;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || drdy !== 1'b0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b drdy=%b dout=%02h, required 0 0 00", busy, drdy, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    din = '0;
    m_res = '0; m_op1 = '0; m_op2 = '0;
    @(negedge clk);
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h31, 8'h03, 8'h04);
  endtask

  task automatic test_back_to_back();
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h20, 8'h00, 8'h00);
    issue(8'h25, 8'h09, 8'h00);
  endtask

  initial begin
    test_reset();
    test_op2_load();
    test_add();
    test_accumulate();
    test_wrap();
    test_subop_and_reserved();
    test_cs_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_tx: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dev_fsm.md
DEV_FSM -- requirements
Module: dev_fsm

Interface
REQ-001 Parameter DW, default 8: width of din, dout and all internal data registers.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cs  input  1  chip select; high for one cycle qualifies din as a command byte.
REQ-005 din  input  DW  command byte, then operand bytes on following cycles.
REQ-006 dout  output  DW  result register value, valid while drdy=1.
REQ-007 busy  output  1  high whenever FSM is not in IDLE.
REQ-008 drdy  output  1  one-cycle strobe marking dout valid.

Function
REQ-009 Command bits (package cmd_bits): b_addop=0, b_subop=1, b_addres=2, b_subres=3, b_op_2=4, b_tx=5; bits 6..DW-1 reserved, ignored.
REQ-010 States SHALL be IDLE, GET_OP1, GET_OP2, EXEC, TX; all outputs registered.
REQ-011 IDLE: at edge with cs=1 latch din as cmd; next state GET_OP1 if any of addop/subop/addres/subres set, else GET_OP2 if b_op_2, else TX if b_tx, else stay IDLE (zero command = no-op).
REQ-012 GET_OP1: latch din into op1 at next edge; then GET_OP2 if b_op_2, else EXEC.
REQ-013 GET_OP2: latch din into op2 register (persistent across transactions); then EXEC.
REQ-014 EXEC (one cycle): apply one arithmetic op, priority addop > subop > addres > subres: addop res=op1+op2; subop res=op1-op2; addres res=res+op1; subres res=res-op1; no arithmetic bit = res unchanged; then TX if b_tx else IDLE.
REQ-015 op2 in EXEC SHALL be the value just loaded if b_op_2 set in this command, else the stored op2.
REQ-016 Arithmetic SHALL be unsigned modulo 2^DW (wrap, no carry/borrow flag).
REQ-017 TX (one cycle): dout=res (incl. result of same-command EXEC), drdy=1; next IDLE; drdy low in all other states.
REQ-018 cs SHALL be ignored outside IDLE; busy SHALL rise on the edge following command capture and fall on entry to IDLE.
REQ-019 Latency: cmd edge + one edge per operand byte + one EXEC edge; drdy asserted the cycle after EXEC (tx-only: the cycle after cmd capture).

Reset
REQ-020 rst=1 SHALL force state IDLE, res=0, op1=0, op2=0, cmd=0, dout=0, busy=0, drdy=0 immediately, including mid-transaction; partial operands discarded.

Structure
REQ-021 Package cmd_bits SHALL hold the bit-position constants and the state enum typedef.
REQ-022 Single module, no sub-modules; optional small combinational ALU function inside dev_fsm.

Verification
REQ-023 Reset, cmd=1<<b_op_2, op2=0x05 -> op2 stored, res unchanged 0, no drdy.
REQ-024 cmd=(1<<b_op_2)|(1<<b_addop), op1=0x03, op2=0x05 -> res=0x08; then cmd=1<<b_tx -> drdy one cycle, dout=0x08.
REQ-025 cmd=1<<b_addres, op1=0x0A -> res=0x12; cmd=1<<b_subres, op1=0x14 -> res=0xFE; tx -> dout=0xFE.
REQ-026 Wrap: res=0xFF, addres op1=0x01 -> res=0x00; cmd=(1<<b_subres)|(1<<b_tx), op1=0x01 -> drdy with dout=0xFF.
REQ-027 cs pulsed while busy -> ignored; rst asserted in GET_OP1 -> IDLE, busy=0, res=0, next command executes normally.
